// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: memWrite codes, requester IDs, in-flight tag.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam logic [1:0] MEMW_READ  = 2'b00;
    localparam logic [1:0] MEMW_WRITE = 2'b01;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic is_read;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, owner: REQ_CPU, is_read: 1'b0};

    function automatic logic [1:0] memw_enc(input logic we);
        return we ? MEMW_WRITE : MEMW_READ;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive denied DMA cycles, saturating at LIMIT; clr wins over inc.
// Latency: at_limit reflects the registered count (one cycle after the inc that reaches it).
// Backpressure: none; pure bookkeeping for the grant logic.
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CPU (fixed priority) and DMA (starvation-protected).
// Latency: grant is combinational; read data returns with rvalid two cycles after the grant.
// Backpressure: a requester holds its request until it sees gnt; cpu_stall flags a denied CPU.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_write,
    input  logic [DW-1:0] mem_rdata
);

    logic dma_starved;

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .reset   (reset),
        .inc     (dma_req & ~dma_gnt),
        .clr     (dma_gnt | ~dma_req),
        .at_limit(dma_starved)
    );

    // Grants are suppressed during reset so a held request is not consumed by a cycle that issues nothing.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (dma_req && dma_starved) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_owner;

    always_comb begin
        sel_owner = dma_gnt ? REQ_DMA : REQ_CPU;
        sel_we    = dma_gnt ? dma_we    : cpu_we;
        sel_addr  = dma_gnt ? dma_addr  : cpu_addr;
        sel_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    end

    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    mem_write_q, mem_write_d;
    tag_t          tag_q,       tag_d;

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = MEMW_READ;
        tag_d       = TAG_NONE;
        if (cpu_gnt || dma_gnt) begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_write_d = memw_enc(sel_we);
            tag_d       = '{valid: 1'b1, owner: sel_owner, is_read: ~sel_we};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= MEMW_READ;
            tag_q       <= TAG_NONE;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            tag_q       <= tag_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;

    // mem_rdata was refreshed on the negedge of this cycle, so it is stable for capture here.
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          dma_rvalid_q, dma_rvalid_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q,  dma_rdata_d;

    always_comb begin
        cpu_rvalid_d = tag_q.valid & tag_q.is_read & (tag_q.owner == REQ_CPU);
        dma_rvalid_d = tag_q.valid & tag_q.is_read & (tag_q.owner == REQ_DMA);
        cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
        dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a transaction-level model.
// Latency: model schedules read returns two cycles after each expected grant.
// Backpressure: bench requesters hold their request until granted.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_write;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_byte(input int i);
        if (i == 0) return 8'h2B;
        if (i == 1) return 8'hCD;
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Byte-wide data memory, access and readout on the negedge.
    logic [7:0] phys [0:65535];
    bit         phys_ready = 1'b0;
    always @(negedge clk) begin
        if (!phys_ready) begin
            for (int i = 0; i < 65536; i++) phys[i] = init_byte(i);
            phys_ready = 1'b1;
        end
        if (mem_write == MEMW_WRITE) begin
            phys[mem_addr]         = mem_wdata[15:8];
            phys[mem_addr + 16'd1] = mem_wdata[7:0];
        end
        mem_rdata = {phys[mem_addr], phys[mem_addr + 16'd1]};
    end

    // Reference: memory contents in grant order plus an event calendar of expected outputs.
    logic [7:0]  ref_mem [0:65535];
    bit          ev_cv [8], ev_dv [8], ev_mw [8];
    logic [15:0] ev_cd [8], ev_dd [8];
    logic [15:0] exp_crd = '0, exp_drd = '0;
    int          cyc = 0, dma_wait = 0;
    int          n_checks = 0, n_fail = 0;
    logic        obs_cg, obs_dg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_grant(input bit is_dma, input logic we, input logic [15:0] a,
                               input logic [15:0] wd);
        int s1, s2;
        s1 = (cyc + 1) & 7;
        s2 = (cyc + 2) & 7;
        if (we) begin
            ref_mem[a]         = wd[15:8];
            ref_mem[a + 16'd1] = wd[7:0];
            ev_mw[s1] = 1'b1;
        end else if (is_dma) begin
            ev_dv[s2] = 1'b1;
            ev_dd[s2] = {ref_mem[a], ref_mem[a + 16'd1]};
        end else begin
            ev_cv[s2] = 1'b1;
            ev_cd[s2] = {ref_mem[a], ref_mem[a + 16'd1]};
        end
    endtask

    // Called at posedge+1 with inputs applied; checks this cycle, advances the model and the clock.
    task automatic tick();
        bit eg_c, eg_d;
        int s;
        #2;
        s = cyc & 7;
        if (reset) begin
            eg_c = 1'b0;
            eg_d = 1'b0;
        end else begin
            eg_d = dma_req && ((dma_wait >= LIMIT) || !cpu_req);
            eg_c = cpu_req && !eg_d;
        end
        obs_cg = cpu_gnt;
        obs_dg = dma_gnt;
        check("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
        check("dma_gnt", 32'(dma_gnt), 32'(eg_d));
        check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eg_c));
        check("mem_write", 32'(mem_write), ev_mw[s] ? 32'h1 : 32'h0);
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(ev_cv[s]));
        check("dma_rvalid", 32'(dma_rvalid), 32'(ev_dv[s]));
        if (ev_cv[s]) exp_crd = ev_cd[s];
        if (ev_dv[s]) exp_drd = ev_dd[s];
        check("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
        check("dma_rdata", 32'(dma_rdata), 32'(exp_drd));
        ev_cv[s] = 1'b0; ev_dv[s] = 1'b0; ev_mw[s] = 1'b0;
        if (reset) begin
            dma_wait = 0;
            exp_crd  = '0;
            exp_drd  = '0;
            for (int k = 0; k < 8; k++) begin
                ev_cv[k] = 1'b0; ev_dv[k] = 1'b0; ev_mw[k] = 1'b0;
            end
        end else begin
            if (eg_c) model_grant(1'b0, cpu_we, cpu_addr, cpu_wdata);
            if (eg_d) model_grant(1'b1, dma_we, dma_addr, dma_wdata);
            dma_wait = (dma_req && !eg_d) ? ((dma_wait + 1 > LIMIT) ? LIMIT : dma_wait + 1) : 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (eg_c) cpu_req = 1'b0;
        if (eg_d) dma_req = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 16'hFFFF;
        return 16'($urandom_range(0, 31));
    endfunction

    logic [5:0] cpat, dpat;

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        for (int k = 0; k < 8; k++) begin
            ev_cv[k] = 1'b0; ev_dv[k] = 1'b0; ev_mw[k] = 1'b0; ev_cd[k] = '0; ev_dd[k] = '0;
        end
        @(posedge clk);
        #1;

        // Reset state, then idle after release.
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Read of a freshly initialised word.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
        tick();
        tick();
        check("t2_rvalid", 32'(cpu_rvalid), 32'h1);
        check("t2_rdata", 32'(cpu_rdata), 32'h2BCD);
        tick();

        // Read-after-write in consecutive grants.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0;
        tick();
        tick();
        check("t3_rvalid", 32'(cpu_rvalid), 32'h1);
        check("t3_rdata", 32'(cpu_rdata), 32'h1234);
        tick();

        // Simultaneous requests: CPU first, DMA next.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0004;
        repeat (5) tick();

        // Continuous contention: DMA wins once after LIMIT denials.
        for (int i = 0; i < 6; i++) begin
            if (!cpu_req) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'(2 * i); end
            if (!dma_req) begin dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020; end
            tick();
            cpat[i] = obs_cg;
            dpat[i] = obs_dg;
        end
        check("t5_cpu_pattern", 32'(cpat), 32'b101111);
        check("t5_dma_pattern", 32'(dpat), 32'b010000);
        repeat (4) tick();

        // Reset right after a DMA read grant drops the response.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0006;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rvalid_n2", 32'(dma_rvalid), 32'h0);
        tick();
        check("t6_rvalid_n3", 32'(dma_rvalid), 32'h0);
        check("t6_mem_write", 32'(mem_write), 32'h0);
        tick();

        // Random mixed traffic with occasional resets.
        repeat (600) begin
            reset = ($urandom_range(0, 149) == 0);
            if (!cpu_req && $urandom_range(0, 99) < 65) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr(); cpu_wdata = 16'($urandom);
            end
            if (!dma_req && $urandom_range(0, 99) < 50) begin
                dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
                dma_addr = rand_addr(); dma_wdata = 16'($urandom);
            end
            tick();
        end
        reset = 1'b0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
